// File: rtl/rr_arbiter128.sv
// Round-robin arbiter: 128 requesters, registered one-hot grant plus binary index, held until done.
// Optional forced release after MAX_HOLD cycles when ARB_GRANT_TIMEOUT_EN is defined.
module rr_arbiter128 #(
  parameter int N_REQ    = 128,
  parameter int IDX_W    = 7,
  parameter int MAX_HOLD = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if ((N_REQ < 2) || (N_REQ != (1 << IDX_W)) || (MAX_HOLD < 1) || (MAX_HOLD > 65535)) begin : g_bad_cfg
    $error("rr_arbiter128: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic [N_REQ-1:0] gnt_r;
  logic             gnt_valid_r;
  logic             timeout_r;

  logic [N_REQ-1:0] rot_s;
  logic [IDX_W-1:0] sel_off_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic             force_s;
  logic             release_s;

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hold_cnt_r;
`endif

  // Rotate req so ptr sits at bit 0; the lowest set bit is then the circular winner.
  always_comb begin
    rot_s     = {N_REQ{1'b0}};
    sel_off_s = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      rot_s[i] = req[IDX_W'(i) + ptr_r];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sel_off_s = rot_s[i] ? IDX_W'(i) : sel_off_s;
    end
    sel_found_s = |rot_s;
    sel_idx_s   = ptr_r + sel_off_s;
  end

  // Release decision for the current owner: done, or hold limit reached without done.
  always_comb begin
    force_s = 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
    if (hold_cnt_r == HOLD_LAST) begin
      force_s = ~done;
    end else begin
      force_s = 1'b0;
    end
`endif
    if (state_r == GRANT) begin
      release_s = done | force_s;
    end else begin
      release_s = 1'b0;
    end
  end

  // Arbiter state, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
      hold_cnt_r  <= 16'd0;
`endif
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sel_found_s) begin
            gnt_r       <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
            gnt_idx_r   <= sel_idx_s;
            gnt_valid_r <= 1'b1;
            state_r     <= GRANT;
`ifdef ARB_GRANT_TIMEOUT_EN
            hold_cnt_r  <= 16'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            gnt_r       <= {N_REQ{1'b0}};
            gnt_idx_r   <= {IDX_W{1'b0}};
            gnt_valid_r <= 1'b0;
            ptr_r       <= gnt_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            timeout_r   <= force_s;
            state_r     <= IDLE;
          end else begin
            state_r     <= GRANT;
`ifdef ARB_GRANT_TIMEOUT_EN
            hold_cnt_r  <= hold_cnt_r + 16'd1;
`endif
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= {N_REQ{1'b0}};
          gnt_idx_r   <= {IDX_W{1'b0}};
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter128.sv
// Directed bench for rr_arbiter128: reset, basic grant, wrap, index sweep, fairness/hold, optional timeout.
module tb_rr_arbiter128;

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 255;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] req;
  logic         done;
  logic [127:0] gnt;
  logic [6:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int vectors = 0;
  int miscompares = 0;

  rr_arbiter128 #(.N_REQ(128), .IDX_W(7), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [127:0] e;
    e = 128'd1 << idx;
    chk({tag, ".gnt"}, gnt, e);
    chk({tag, ".idx"}, {121'd0, gnt_idx}, 128'(idx));
    chk({tag, ".valid"}, {127'd0, gnt_valid}, 128'd1);
    chk({tag, ".onehot"}, {127'd0, $onehot(gnt)}, 128'd1);
    chk({tag, ".timeout"}, {127'd0, timeout}, 128'd0);
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, ".gnt"}, gnt, 128'd0);
    chk({tag, ".idx"}, {121'd0, gnt_idx}, 128'd0);
    chk({tag, ".valid"}, {127'd0, gnt_valid}, 128'd0);
    chk({tag, ".timeout"}, {127'd0, timeout}, {127'd0, exp_to});
  endtask

  initial begin
    // 1. reset with all requests asserted
    rst_n = 1'b0;
    req   = {128{1'b1}};
    done  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("reset", 1'b0);
    end
    rst_n = 1'b1;
    tick();
    chk_grant("rst_first", 0);
    req   = 128'd0;
    rst_n = 1'b0;
    tick();
    chk_idle("rst_mid_grant", 1'b0);
    rst_n = 1'b1;

    // 2. basic grant from ptr=0
    req = (128'd1 << 5) | (128'd1 << 12);
    tick();
    chk_grant("basic5", 5);
    done = 1'b1;
    tick();
    chk_idle("basic_gap", 1'b0);
    done = 1'b0;
    tick();
    chk_grant("basic12", 12);
    done = 1'b1;
    req  = 128'd0;
    tick();
    chk_idle("basic_rel", 1'b0);
    done = 1'b0;

    // 3. wrap-around, release together with new requests
    req = 128'd1 << 126;
    tick();
    chk_grant("wrap126", 126);
    done = 1'b1;
    req  = (128'd1 << 127) | 128'd1;
    tick();
    chk_idle("wrap_gap1", 1'b0);
    done = 1'b0;
    tick();
    chk_grant("wrap127", 127);
    done = 1'b1;
    tick();
    chk_idle("wrap_gap2", 1'b0);
    done = 1'b0;
    tick();
    chk_grant("wrap0", 0);
    req  = 128'd0;
    done = 1'b1;
    tick();
    chk_idle("wrap_rel", 1'b0);
    done = 1'b0;
    req  = 128'd3;
    tick();
    chk_grant("ptr_is_1", 1);
    done = 1'b1;
    req  = 128'd0;
    tick();
    chk_idle("ptr_rel", 1'b0);

    // done held high in IDLE is ignored; it then releases the new grant
    tick();
    chk_idle("done_idle", 1'b0);
    req = 128'd1 << 7;
    tick();
    chk_grant("done_ign", 7);
    req = 128'd0;
    tick();
    chk_idle("done_ign_rel", 1'b0);
    done = 1'b0;

    // 4. single-bit index sweep
    for (int i = 0; i < 128; i++) begin
      req = 128'd1 << i;
      tick();
      chk_grant("sweep", i);
      done = 1'b1;
      req  = 128'd0;
      tick();
      chk_idle("sweep_rel", 1'b0);
      done = 1'b0;
    end

    // 5. fairness with all requests, done in the third grant cycle; owner drops req at k=5
    req = {128{1'b1}};
    for (int k = 0; k <= 128; k++) begin
      tick();
      chk_grant("fair", k % 128);
      if (k == 5) begin
        req[5] = 1'b0;
      end
      tick();
      chk_grant("fair_hold2", k % 128);
      tick();
      chk_grant("fair_hold3", k % 128);
      req  = {128{1'b1}};
      done = 1'b1;
      tick();
      chk_idle("fair_rel", 1'b0);
      done = 1'b0;
    end
    req = 128'd0;

`ifdef ARB_GRANT_TIMEOUT_EN
    // 6. forced release after HOLD cycles, then a done coinciding with the limit
    req = 128'd1 << 3;
    tick();
    chk_grant("to_c1", 3);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_grant("to_hold", 3);
    end
    tick();
    chk_idle("to_pulse", 1'b1);
    tick();
    chk_grant("to_regrant", 3);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_grant("to_hold2", 3);
    end
    done = 1'b1;
    req  = 128'd0;
    tick();
    chk_idle("to_done_wins", 1'b0);
    done = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
